program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, sets the program-memory address width and the prog_len width.
REQ-002 Parameter DEPTH_WIDTH, default 8, sets the bracket-nesting counter width.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  source character is presented on in_data.
REQ-006 in_ready  output  1  loader accepts a character this cycle.
REQ-007 in_data  input  8  ASCII source character.
REQ-008 in_last  input  1  qualifies in_data as the final character of the source.
REQ-009 pmem_we  output  1  one-cycle program-memory write strobe.
REQ-010 pmem_addr  output  ADDR_WIDTH  program-memory write address.
REQ-011 pmem_data_write  output  3  encoded opcode to write.
REQ-012 prog_len  output  ADDR_WIDTH  number of opcodes written so far.
REQ-013 run  output  1  high only in DONE; releases the core from hold.
REQ-014 error  output  1  high only in ERROR.
REQ-015 error_code  output  2  0 none, 1 program overflow, 2 unmatched ']', 3 unclosed '[' or nesting overflow.

Function
REQ-016 The loader SHALL have exactly three states, LOAD, DONE and ERROR; it enters LOAD on reset.
REQ-017 in_ready SHALL be high in LOAD and low in DONE and ERROR; a character is accepted on a cycle where in_valid and in_ready are both high.
REQ-018 Encoding SHALL be '+'(0x2B)->0, '-'(0x2D)->1, '>'(0x3E)->2, '<'(0x3C)->3, '['(0x5B)->4, ']'(0x5D)->5, '.'(0x2E)->6, ','(0x2C)->7.
REQ-019 Any other accepted byte SHALL be discarded with no write and no prog_len change.
REQ-020 For a recognised accepted character, pmem_we SHALL be high for exactly one cycle, on the cycle after acceptance, with pmem_addr equal to the pre-increment prog_len and pmem_data_write equal to the opcode.
REQ-021 prog_len SHALL increment by 1 on the same edge that registers the write.
REQ-022 Back-to-back accepts SHALL sustain one write per cycle with no bubbles.
REQ-023 Capacity SHALL be 2^ADDR_WIDTH-1 opcodes; a recognised character accepted with prog_len at capacity SHALL cause no write and a transition to ERROR with code 1.
REQ-024 An accepted character with in_last high SHALL be processed normally, and the loader SHALL then enter DONE on the next cycle, unless an error takes precedence.
REQ-025 in_last on an unrecognised character with prog_len 0 SHALL enter DONE with prog_len 0 (empty program).
REQ-026 DONE and ERROR SHALL be sticky until reset; in_valid SHALL be ignored in both.
REQ-027 Error checks SHALL apply in priority order 1, 2, 3 when several conditions occur on one character.
REQ-028 No write SHALL occur for the character that causes an error.

Reset
REQ-029 While reset_n is sampled low, the loader SHALL set state to LOAD and clear pmem_we, pmem_addr, pmem_data_write, prog_len, run, error, error_code and the nesting depth to 0.
REQ-030 Reset asserted mid-load SHALL abandon the load; any write pending for the following cycle SHALL be suppressed.
REQ-031 Memory already written SHALL not be cleared by reset.

Configuration
REQ-032 With macro BRACKET_CHECK_EN defined, the loader SHALL track nesting depth: '[' increments it, ']' decrements it.
REQ-033 With BRACKET_CHECK_EN defined, ']' at depth 0 SHALL raise code 2, '[' at depth 2^DEPTH_WIDTH-1 SHALL raise code 3, and in_last with final depth nonzero SHALL raise code 3 instead of entering DONE.
REQ-034 Without BRACKET_CHECK_EN, no depth counter SHALL exist, brackets SHALL be written like any other opcode, and codes 2 and 3 SHALL never occur.

Verification
REQ-035 Stream "+-><[].," with in_last on ',' -> eight writes at addr 0..7 with data 0..7, prog_len=8, run=1 on the cycle after the last accept.
REQ-036 Stream "a+ \n-" with in_last on '-', in_valid held high -> two writes (addr0=0, addr1=1), prog_len=2, run=1.
REQ-037 BRACKET_CHECK_EN defined, stream "+]" -> single write of 0 at addr 0, error=1, error_code=2, in_ready=0, no further writes.
REQ-038 BRACKET_CHECK_EN defined, stream "[[]" with in_last on ']' -> error_code=3, run=0; without the macro -> three writes (4,4,5) and run=1.
REQ-039 ADDR_WIDTH=2, stream "++++" -> writes at addr 0..2, fourth '+' gives error_code=1, prog_len=3.
REQ-040 reset_n pulled low on the cycle after accepting '+' -> no pmem_we, prog_len=0, state LOAD, in_ready=1 after release.

Source files
------------

// File: rtl/program_loader.sv
// Streams ASCII program text into program memory as 3-bit opcodes, then releases the core.
// Define BRACKET_CHECK_EN to add bracket-nesting validation (error codes 2 and 3).
module program_loader #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  pmem_we,
  output logic [ADDR_WIDTH-1:0] pmem_addr,
  output logic [2:0]            pmem_data_write,
  output logic [ADDR_WIDTH-1:0] prog_len,
  output logic                  run,
  output logic                  error,
  output logic [1:0]            error_code
);

  // state | meaning
  // LOAD  | accepting source characters, writing opcodes
  // DONE  | program complete, core released via run
  // ERROR | load aborted, error_code holds the cause
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DONE  = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [ADDR_WIDTH-1:0] CAPACITY = {ADDR_WIDTH{1'b1}};

  if (ADDR_WIDTH < 1 || DEPTH_WIDTH < 1) begin : g_param_check
    $error("program_loader: ADDR_WIDTH and DEPTH_WIDTH must be at least 1");
  end

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              data_q, data_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic [1:0]              code_q, code_d;
  logic                    accept;
  logic                    known;
  logic [2:0]              opcode;

`ifdef BRACKET_CHECK_EN
  localparam logic [1:0] ERR_UNMATCHED = 2'd2;
  localparam logic [1:0] ERR_NESTING   = 2'd3;
  localparam logic [2:0] OP_OPEN       = 3'd4;
  localparam logic [2:0] OP_CLOSE      = 3'd5;
  localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = {DEPTH_WIDTH{1'b1}};

  logic [DEPTH_WIDTH-1:0]  depth_q, depth_d, depth_next;
  logic                    is_open, is_close;

  assign is_open  = known && (opcode == OP_OPEN);
  assign is_close = known && (opcode == OP_CLOSE);

  always_comb begin
    depth_next = depth_q;
    if (is_open)
      depth_next = depth_q + 1'b1;
    else if (is_close)
      depth_next = depth_q - 1'b1;
  end
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    known  = 1'b1;
    opcode = 3'd0;
    case (in_data)
      8'h2B:   opcode = 3'd0;
      8'h2D:   opcode = 3'd1;
      8'h3E:   opcode = 3'd2;
      8'h3C:   opcode = 3'd3;
      8'h5B:   opcode = 3'd4;
      8'h5D:   opcode = 3'd5;
      8'h2E:   opcode = 3'd6;
      8'h2C:   opcode = 3'd7;
      default: known  = 1'b0;
    endcase
  end

  // Errors are checked before any write so the offending character never lands in memory.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    len_d   = len_q;
    code_d  = code_q;
`ifdef BRACKET_CHECK_EN
    depth_d = depth_q;
`endif
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          if (known && (len_q == CAPACITY)) begin
            state_d = ERROR;
            code_d  = ERR_OVERFLOW;
          end
`ifdef BRACKET_CHECK_EN
          else if (is_close && (depth_q == '0)) begin
            state_d = ERROR;
            code_d  = ERR_UNMATCHED;
          end
          else if (is_open && (depth_q == DEPTH_MAX)) begin
            state_d = ERROR;
            code_d  = ERR_NESTING;
          end
          else if (in_last && (depth_next != '0)) begin
            state_d = ERROR;
            code_d  = ERR_NESTING;
          end
`endif
          else begin
            if (known) begin
              we_d   = 1'b1;
              addr_d = len_q;
              data_d = opcode;
              len_d  = len_q + 1'b1;
`ifdef BRACKET_CHECK_EN
              depth_d = depth_next;
`endif
            end
            if (in_last)
              state_d = DONE;
          end
        end
      end
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= LOAD;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 3'd0;
      len_q   <= '0;
      code_q  <= ERR_NONE;
`ifdef BRACKET_CHECK_EN
      depth_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      len_q   <= len_d;
      code_q  <= code_d;
`ifdef BRACKET_CHECK_EN
      depth_q <= depth_d;
`endif
    end
  end

  // Gating with reset_n drops a write that was registered just before reset asserted.
  assign pmem_we         = we_q && reset_n;
  assign pmem_addr       = addr_q;
  assign pmem_data_write = data_q;
  assign prog_len        = len_q;
  assign in_ready        = (state_q == LOAD);
  assign run             = (state_q == DONE);
  assign error           = (state_q == ERROR);
  assign error_code      = code_q;

endmodule
